// File: rtl/mac_cam_learner_pkg.sv
// Shared definitions for the MAC CAM learner.
// Holds the FSM state type, the table entry field layout, the broadcast MAC
// and the index of the Ethernet group (multicast) bit.
// Entry layout, LSB first: mac[47:0], oq[NQ-1:0], protect, valid.
package mac_cam_learner_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SEARCH   = 3'd2,
    ST_CAM_WR   = 3'd3,
    ST_CAM_WAIT = 3'd4
  } state_t;

  localparam int unsigned MAC_W     = 48;
  localparam int unsigned MAC_LSB   = 0;
  localparam int unsigned OQ_LSB    = MAC_W;
  localparam int unsigned GROUP_BIT = 40;

  localparam logic [MAC_W-1:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  function automatic int unsigned protect_bit(input int unsigned nq);
    return OQ_LSB + nq;
  endfunction

  function automatic int unsigned valid_bit(input int unsigned nq);
    return OQ_LSB + nq + 1;
  endfunction

  function automatic int unsigned entry_w(input int unsigned nq);
    return MAC_W + nq + 2;
  endfunction

endpackage

// File: rtl/mac_learn_table.sv
// Shadow table of the MAC CAM: one {valid, protect, oq, mac} entry per CAM
// address.
// Ports:
//   clk, reset          - clock, synchronous active-high reset (read port only)
//   we, wr_*            - single write port, full entry per write
//   rd_addr, rd_*       - registered read port, 1-cycle latency
//   search_mac          - key for the parallel compare
//   hit, hit_idx        - lowest valid entry whose mac equals search_mac
//   free_idx, any_free  - lowest invalid entry
//   peek_addr, peek_*   - combinational view of one entry's protect/oq
module mac_learn_table #(
  parameter int unsigned NUM_OUTPUT_QUEUES = 8,
  parameter int unsigned LUT_DEPTH_BITS    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [LUT_DEPTH_BITS-1:0]    wr_addr,
  input  logic                         wr_valid,
  input  logic                         wr_protect,
  input  logic [NUM_OUTPUT_QUEUES-1:0] wr_oq,
  input  logic [47:0]                  wr_mac,
  input  logic [LUT_DEPTH_BITS-1:0]    rd_addr,
  output logic [NUM_OUTPUT_QUEUES-1:0] rd_oq,
  output logic [47:0]                  rd_mac,
  output logic                         rd_protect,
  input  logic [47:0]                  search_mac,
  output logic                         hit,
  output logic [LUT_DEPTH_BITS-1:0]    hit_idx,
  output logic [LUT_DEPTH_BITS-1:0]    free_idx,
  output logic                         any_free,
  input  logic [LUT_DEPTH_BITS-1:0]    peek_addr,
  output logic                         peek_protect,
  output logic [NUM_OUTPUT_QUEUES-1:0] peek_oq
);
  import mac_cam_learner_pkg::*;

  localparam int unsigned LUT_DEPTH = 2**LUT_DEPTH_BITS;
  localparam int unsigned EW        = entry_w(NUM_OUTPUT_QUEUES);
  localparam int unsigned PB        = protect_bit(NUM_OUTPUT_QUEUES);
  localparam int unsigned VB        = valid_bit(NUM_OUTPUT_QUEUES);

  logic [EW-1:0] entry [LUT_DEPTH];

  // No reset on the array: the INIT sequence rewrites every entry before
  // any search can look at it.
  always_ff @(posedge clk) begin
    if (we) entry[wr_addr] <= {wr_valid, wr_protect, wr_oq, wr_mac};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_oq      <= '0;
      rd_mac     <= '0;
      rd_protect <= 1'b0;
    end else begin
      rd_oq      <= entry[rd_addr][OQ_LSB +: NUM_OUTPUT_QUEUES];
      rd_mac     <= entry[rd_addr][MAC_LSB +: MAC_W];
      rd_protect <= entry[rd_addr][PB];
    end
  end

  // Scan from the top down so the lowest matching / free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    any_free = 1'b0;
    free_idx = '0;
    for (int unsigned i = LUT_DEPTH; i > 0; i--) begin
      if (entry[i-1][VB] && (entry[i-1][MAC_LSB +: MAC_W] == search_mac)) begin
        hit     = 1'b1;
        hit_idx = LUT_DEPTH_BITS'(i-1);
      end
      if (!entry[i-1][VB]) begin
        any_free = 1'b1;
        free_idx = LUT_DEPTH_BITS'(i-1);
      end
    end
  end

  assign peek_protect = entry[peek_addr][PB];
  assign peek_oq      = entry[peek_addr][OQ_LSB +: NUM_OUTPUT_QUEUES];

endmodule

// File: rtl/mac_cam_learner.sv
// Write side of the learning switch MAC CAM: initialises the CAM and its
// shadow table after reset, learns source MAC/port pairs and services host
// writes.
// Ports:
//   clk, reset                        - clock, synchronous active-high reset
//   learn_mac/port/req, learn_ack     - learn handshake (req held until ack)
//   wr_addr/req/oq/protect/mac, wr_ack - host entry write, ack is a pulse
//   cam_we, cam_wr_addr, cam_din      - CAM write strobe and data
//   cam_busy                          - CAM write in progress
//   lut_rd_addr, lut_rd_*             - registered table read for the lookup side
//   init_done                         - initialisation complete
//   learn_new/update/drop             - one-cycle learn outcome pulses
module mac_cam_learner #(
  parameter int unsigned                   NUM_OUTPUT_QUEUES         = 8,
  parameter int unsigned                   NUM_IQ_BITS               = 3,
  parameter int unsigned                   LUT_DEPTH_BITS            = 4,
  parameter int unsigned                   LUT_DEPTH                 = 2**LUT_DEPTH_BITS,
  parameter logic [NUM_OUTPUT_QUEUES-1:0]  DEFAULT_MISS_OUTPUT_PORTS = NUM_OUTPUT_QUEUES'(8'h55)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [47:0]                  learn_mac,
  input  logic [NUM_IQ_BITS-1:0]       learn_port,
  input  logic                         learn_req,
  output logic                         learn_ack,
  input  logic [LUT_DEPTH_BITS-1:0]    wr_addr,
  input  logic                         wr_req,
  input  logic [NUM_OUTPUT_QUEUES-1:0] wr_oq,
  input  logic                         wr_protect,
  input  logic [47:0]                  wr_mac,
  output logic                         wr_ack,
  output logic                         cam_we,
  output logic [LUT_DEPTH_BITS-1:0]    cam_wr_addr,
  output logic [47:0]                  cam_din,
  input  logic                         cam_busy,
  input  logic [LUT_DEPTH_BITS-1:0]    lut_rd_addr,
  output logic [NUM_OUTPUT_QUEUES-1:0] lut_rd_oq,
  output logic [47:0]                  lut_rd_mac,
  output logic                         lut_rd_protect,
  output logic                         init_done,
  output logic                         learn_new,
  output logic                         learn_update,
  output logic                         learn_drop
);
  import mac_cam_learner_pkg::*;

  localparam logic [LUT_DEPTH_BITS-1:0] LAST_IDX   = LUT_DEPTH_BITS'(LUT_DEPTH-1);
  localparam logic [LUT_DEPTH_BITS-1:0] VICTIM_MAX = LUT_DEPTH_BITS'(LUT_DEPTH-2);

  state_t                         state;
  logic [LUT_DEPTH_BITS-1:0]      init_ptr;
  logic [LUT_DEPTH_BITS-1:0]      victim_ptr;
  logic [LUT_DEPTH_BITS-1:0]      next_victim;
  logic [47:0]                    lmac_q;
  logic [NUM_OUTPUT_QUEUES-1:0]   loq_q;
  logic [NUM_OUTPUT_QUEUES-1:0]   learn_dec;
  logic                           cur_learn;
  logic                           mac_bad;

  logic                           t_we;
  logic [LUT_DEPTH_BITS-1:0]      t_addr;
  logic                           t_valid;
  logic                           t_protect;
  logic [NUM_OUTPUT_QUEUES-1:0]   t_oq;
  logic [47:0]                    t_mac;

  logic                           hit;
  logic                           any_free;
  logic                           peek_protect;
  logic [LUT_DEPTH_BITS-1:0]      hit_idx;
  logic [LUT_DEPTH_BITS-1:0]      free_idx;
  logic [LUT_DEPTH_BITS-1:0]      peek_addr;
  logic [NUM_OUTPUT_QUEUES-1:0]   peek_oq;

  mac_learn_table #(
    .NUM_OUTPUT_QUEUES (NUM_OUTPUT_QUEUES),
    .LUT_DEPTH_BITS    (LUT_DEPTH_BITS)
  ) u_table (
    .clk          (clk),
    .reset        (reset),
    .we           (t_we),
    .wr_addr      (t_addr),
    .wr_valid     (t_valid),
    .wr_protect   (t_protect),
    .wr_oq        (t_oq),
    .wr_mac       (t_mac),
    .rd_addr      (lut_rd_addr),
    .rd_oq        (lut_rd_oq),
    .rd_mac       (lut_rd_mac),
    .rd_protect   (lut_rd_protect),
    .search_mac   (lmac_q),
    .hit          (hit),
    .hit_idx      (hit_idx),
    .free_idx     (free_idx),
    .any_free     (any_free),
    .peek_addr    (peek_addr),
    .peek_protect (peek_protect),
    .peek_oq      (peek_oq)
  );

  always_comb begin
    learn_dec = '0;
    for (int unsigned i = 0; i < NUM_OUTPUT_QUEUES; i++) begin
      if (32'(learn_port) == i) learn_dec[i] = 1'b1;
    end
  end

  assign mac_bad     = (lmac_q == '0) || lmac_q[GROUP_BIT];
  assign peek_addr   = hit ? hit_idx : victim_ptr;
  assign next_victim = (victim_ptr == VICTIM_MAX) ? '0 : victim_ptr + 1'b1;

  // The strobe is combinational so it can follow cam_busy in the same cycle.
  assign cam_we = (state == ST_CAM_WR) && !cam_busy && !reset;

  // Table write port: INIT entry, host write, or SEARCH outcome.
  always_comb begin
    t_we      = 1'b0;
    t_addr    = init_ptr;
    t_valid   = 1'b0;
    t_protect = 1'b0;
    t_oq      = '0;
    t_mac     = '0;
    case (state)
      ST_INIT: begin
        t_we = 1'b1;
        if (init_ptr == LAST_IDX) begin
          t_valid   = 1'b1;
          t_protect = 1'b1;
          t_oq      = DEFAULT_MISS_OUTPUT_PORTS;
          t_mac     = BCAST_MAC;
        end
      end
      ST_IDLE: begin
        if (wr_req) begin
          t_we      = 1'b1;
          t_addr    = wr_addr;
          t_valid   = (wr_mac != '0);
          t_protect = wr_protect;
          t_oq      = wr_oq;
          t_mac     = wr_mac;
        end
      end
      ST_SEARCH: begin
        t_valid = 1'b1;
        t_oq    = loq_q;
        t_mac   = lmac_q;
        if (!mac_bad) begin
          if (hit) begin
            t_addr = hit_idx;
            t_we   = !peek_protect && (peek_oq != loq_q);
          end else if (any_free) begin
            t_addr = free_idx;
            t_we   = 1'b1;
          end else begin
            t_addr = victim_ptr;
            t_we   = !peek_protect;
          end
        end
      end
      default: ;
    endcase
    if (reset) t_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_INIT;
      init_ptr     <= '0;
      victim_ptr   <= '0;
      init_done    <= 1'b0;
      learn_ack    <= 1'b0;
      wr_ack       <= 1'b0;
      learn_new    <= 1'b0;
      learn_update <= 1'b0;
      learn_drop   <= 1'b0;
      cam_wr_addr  <= '0;
      cam_din      <= '0;
      lmac_q       <= '0;
      loq_q        <= '0;
      cur_learn    <= 1'b0;
    end else begin
      wr_ack       <= 1'b0;
      learn_new    <= 1'b0;
      learn_update <= 1'b0;
      learn_drop   <= 1'b0;
      if (learn_ack && !learn_req) learn_ack <= 1'b0;

      case (state)
        ST_INIT: begin
          cam_wr_addr <= init_ptr;
          cam_din     <= (init_ptr == LAST_IDX) ? BCAST_MAC : '0;
          cur_learn   <= 1'b0;
          state       <= ST_CAM_WR;
        end
        ST_IDLE: begin
          if (wr_req) begin
            cam_wr_addr <= wr_addr;
            cam_din     <= wr_mac;
            wr_ack      <= 1'b1;
            cur_learn   <= 1'b0;
            state       <= ST_CAM_WR;
          end else if (learn_req && !learn_ack) begin
            lmac_q <= learn_mac;
            loq_q  <= learn_dec;
            state  <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          state <= ST_IDLE;
          if (mac_bad) begin
            learn_drop <= 1'b1;
            learn_ack  <= 1'b1;
          end else if (hit) begin
            learn_update <= t_we;
            learn_ack    <= 1'b1;
          end else if (any_free || !peek_protect) begin
            cam_wr_addr <= t_addr;
            cam_din     <= lmac_q;
            learn_new   <= 1'b1;
            cur_learn   <= 1'b1;
            state       <= ST_CAM_WR;
            if (!any_free) victim_ptr <= next_victim;
          end else begin
            learn_drop <= 1'b1;
            learn_ack  <= 1'b1;
            victim_ptr <= next_victim;
          end
        end
        ST_CAM_WR: begin
          if (!cam_busy) state <= ST_CAM_WAIT;
        end
        ST_CAM_WAIT: begin
          if (!cam_busy) begin
            if (!init_done) begin
              if (init_ptr == LAST_IDX) begin
                init_done <= 1'b1;
                state     <= ST_IDLE;
              end else begin
                init_ptr <= init_ptr + 1'b1;
                state    <= ST_INIT;
              end
            end else begin
              state <= ST_IDLE;
              if (cur_learn) learn_ack <= 1'b1;
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_cam_learner.sv
`timescale 1ns/1ps
module tb_mac_cam_learner;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] learn_mac;
  logic [2:0]  learn_port;
  logic        learn_req;
  logic        learn_ack;
  logic [3:0]  wr_addr;
  logic        wr_req;
  logic [7:0]  wr_oq;
  logic        wr_protect;
  logic [47:0] wr_mac;
  logic        wr_ack;
  logic        cam_we;
  logic [3:0]  cam_wr_addr;
  logic [47:0] cam_din;
  logic        cam_busy;
  logic [3:0]  lut_rd_addr;
  logic [7:0]  lut_rd_oq;
  logic [47:0] lut_rd_mac;
  logic        lut_rd_protect;
  logic        init_done;
  logic        learn_new;
  logic        learn_update;
  logic        learn_drop;

  int n_vec = 0;
  int n_bad = 0;

  typedef enum int {EV_WR_ACK, EV_CAM_WE, EV_NEW, EV_UPD, EV_DROP, EV_ACK} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [3:0]  addr;
    logic [47:0] data;
  } ev_t;
  ev_t exp_q[$];

  mac_cam_learner #(
    .NUM_OUTPUT_QUEUES         (8),
    .NUM_IQ_BITS               (3),
    .LUT_DEPTH_BITS            (4),
    .LUT_DEPTH                 (16),
    .DEFAULT_MISS_OUTPUT_PORTS (8'h55)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .learn_mac      (learn_mac),
    .learn_port     (learn_port),
    .learn_req      (learn_req),
    .learn_ack      (learn_ack),
    .wr_addr        (wr_addr),
    .wr_req         (wr_req),
    .wr_oq          (wr_oq),
    .wr_protect     (wr_protect),
    .wr_mac         (wr_mac),
    .wr_ack         (wr_ack),
    .cam_we         (cam_we),
    .cam_wr_addr    (cam_wr_addr),
    .cam_din        (cam_din),
    .cam_busy       (cam_busy),
    .lut_rd_addr    (lut_rd_addr),
    .lut_rd_oq      (lut_rd_oq),
    .lut_rd_mac     (lut_rd_mac),
    .lut_rd_protect (lut_rd_protect),
    .init_done      (init_done),
    .learn_new      (learn_new),
    .learn_update   (learn_update),
    .learn_drop     (learn_drop)
  );

  always #5 clk = ~clk;

  // CAM model: busy for 16 cycles after every write strobe.
  int busy_cnt = 0;
  assign cam_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (cam_we) busy_cnt <= 16;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic expect_ev(input ev_kind_t k, input logic [3:0] a, input logic [47:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input logic [3:0] a, input logic [47:0] d);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got %s addr=%0d data=%h, required no event", k.name(), a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_CAM_WE && (e.addr != a || e.data != d))) begin
        n_bad++;
        $display("FAIL event: got %s addr=%0d data=%h, required %s addr=%0d data=%h",
                 k.name(), a, d, e.kind.name(), e.addr, e.data);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    logic prev_ack;
    logic prev_we;
    prev_ack = 1'b0;
    prev_we  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ack = 1'b0;
        prev_we  = 1'b0;
      end else begin
        if (wr_ack) observe(EV_WR_ACK, '0, '0);
        if (cam_we) begin
          n_vec++;
          if (cam_busy || prev_we) begin
            n_bad++;
            $display("FAIL cam_we_rule: got cam_we=1 with busy=%0b prev_we=%0b, required both 0", cam_busy, prev_we);
          end
          observe(EV_CAM_WE, cam_wr_addr, cam_din);
        end
        if (learn_new)    observe(EV_NEW, '0, '0);
        if (learn_update) observe(EV_UPD, '0, '0);
        if (learn_drop)   observe(EV_DROP, '0, '0);
        if (learn_ack && !prev_ack) observe(EV_ACK, '0, '0);
        prev_ack = learn_ack;
        prev_we  = cam_we;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    n_vec++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic check_lut(input logic [3:0] idx, input logic [7:0] oq, input logic [47:0] mac, input logic prot);
    lut_rd_addr = idx;
    tick(1);
    chk($sformatf("lut%0d_oq", idx), 64'(lut_rd_oq), 64'(oq));
    chk($sformatf("lut%0d_mac", idx), 64'(lut_rd_mac), 64'(mac));
    chk($sformatf("lut%0d_protect", idx), 64'(lut_rd_protect), 64'(prot));
  endtask

  task automatic wait_ack(input string name, input int bound);
    int n;
    n = 0;
    while (!learn_ack && n < bound) begin
      tick(1);
      n++;
    end
    chk({name, "_ack"}, 64'(learn_ack), 64'd1);
  endtask

  task automatic do_learn(input string name, input logic [47:0] mac, input logic [2:0] port);
    learn_mac  = mac;
    learn_port = port;
    learn_req  = 1'b1;
    wait_ack(name, 400);
    learn_req  = 1'b0;
    tick(2);
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!init_done && n < 2000) begin
      tick(1);
      n++;
    end
    chk(name, 64'(init_done), 64'd1);
  endtask

  task automatic expect_init();
    for (int i = 0; i < 16; i++)
      expect_ev(EV_CAM_WE, 4'(i), (i == 15) ? 48'hFFFF_FFFF_FFFF : 48'h0);
  endtask

  initial begin
    logic [47:0] m;
    reset       = 1'b1;
    learn_mac   = '0;
    learn_port  = '0;
    learn_req   = 1'b0;
    wr_addr     = '0;
    wr_req      = 1'b0;
    wr_oq       = '0;
    wr_protect  = 1'b0;
    wr_mac      = '0;
    lut_rd_addr = '0;
    tick(3);

    // Reset values
    chk("rst_learn_ack", 64'(learn_ack), 0);
    chk("rst_wr_ack", 64'(wr_ack), 0);
    chk("rst_cam_we", 64'(cam_we), 0);
    chk("rst_pulses", 64'({learn_new, learn_update, learn_drop}), 0);
    chk("rst_init_done", 64'(init_done), 0);
    chk("rst_cam_wr_addr", 64'(cam_wr_addr), 0);
    chk("rst_cam_din", 64'(cam_din), 0);
    chk("rst_lut_rd", 64'({lut_rd_protect, lut_rd_oq, lut_rd_mac}), 0);

    // Initialisation: 16 CAM writes, broadcast entry last
    expect_init();
    reset = 1'b0;
    wait_init("init_done");
    check_lut(4'd15, 8'h55, 48'hFFFF_FFFF_FFFF, 1'b1);
    check_lut(4'd0, 8'h00, 48'h0, 1'b0);

    // New learn lands in entry 0
    expect_ev(EV_CAM_WE, 4'd0, 48'h0011_2233_4455);
    expect_ev(EV_NEW, '0, '0);
    expect_ev(EV_ACK, '0, '0);
    do_learn("learn_new0", 48'h0011_2233_4455, 3'd2);
    check_lut(4'd0, 8'h04, 48'h0011_2233_4455, 1'b0);

    // Port move: update only, ack at N+2
    expect_ev(EV_UPD, '0, '0);
    expect_ev(EV_ACK, '0, '0);
    learn_mac  = 48'h0011_2233_4455;
    learn_port = 3'd4;
    learn_req  = 1'b1;
    tick(1);
    chk("upd_ack_n1", 64'(learn_ack), 0);
    tick(1);
    chk("upd_ack_n2", 64'(learn_ack), 1);
    learn_req = 1'b0;
    tick(2);
    check_lut(4'd0, 8'h10, 48'h0011_2233_4455, 1'b0);

    // Group and zero MACs are dropped
    expect_ev(EV_DROP, '0, '0);
    expect_ev(EV_ACK, '0, '0);
    do_learn("drop_group", 48'h0100_5E00_0001, 3'd1);
    expect_ev(EV_DROP, '0, '0);
    expect_ev(EV_ACK, '0, '0);
    do_learn("drop_zero", 48'h0, 3'd1);

    // Fill entries 1..14
    for (int i = 1; i < 15; i++) begin
      m = 48'h0000_0000_0100 + 48'(i);
      expect_ev(EV_CAM_WE, 4'(i), m);
      expect_ev(EV_NEW, '0, '0);
      expect_ev(EV_ACK, '0, '0);
      do_learn($sformatf("fill%0d", i), m, 3'(i % 8));
    end

    // Table full: replace victim 0, then victim 1
    expect_ev(EV_CAM_WE, 4'd0, 48'h0000_0000_0200);
    expect_ev(EV_NEW, '0, '0);
    expect_ev(EV_ACK, '0, '0);
    do_learn("victim0", 48'h0000_0000_0200, 3'd1);
    check_lut(4'd0, 8'h02, 48'h0000_0000_0200, 1'b0);
    expect_ev(EV_CAM_WE, 4'd1, 48'h0000_0000_0201);
    expect_ev(EV_NEW, '0, '0);
    expect_ev(EV_ACK, '0, '0);
    do_learn("victim1", 48'h0000_0000_0201, 3'd3);
    check_lut(4'd15, 8'h55, 48'hFFFF_FFFF_FFFF, 1'b1);

    // Host write and learn together: host write goes first
    expect_ev(EV_WR_ACK, '0, '0);
    expect_ev(EV_CAM_WE, 4'd3, 48'h0000_0000_0ABC);
    expect_ev(EV_CAM_WE, 4'd2, 48'h0000_0000_0300);
    expect_ev(EV_NEW, '0, '0);
    expect_ev(EV_ACK, '0, '0);
    wr_addr    = 4'd3;
    wr_mac     = 48'h0000_0000_0ABC;
    wr_oq      = 8'h81;
    wr_protect = 1'b1;
    wr_req     = 1'b1;
    learn_mac  = 48'h0000_0000_0300;
    learn_port = 3'd5;
    learn_req  = 1'b1;
    tick(1);
    wr_req = 1'b0;
    wait_ack("wr_and_learn", 400);
    learn_req = 1'b0;
    tick(2);
    check_lut(4'd3, 8'h81, 48'h0000_0000_0ABC, 1'b1);
    check_lut(4'd2, 8'h20, 48'h0000_0000_0300, 1'b0);

    // Protected victim (entry 3): drop, victim moves on to 4
    expect_ev(EV_DROP, '0, '0);
    expect_ev(EV_ACK, '0, '0);
    do_learn("victim_prot", 48'h0000_0000_0400, 3'd0);
    expect_ev(EV_CAM_WE, 4'd4, 48'h0000_0000_0500);
    expect_ev(EV_NEW, '0, '0);
    expect_ev(EV_ACK, '0, '0);
    do_learn("victim4", 48'h0000_0000_0500, 3'd6);

    // Hit on a protected entry: ack only
    expect_ev(EV_ACK, '0, '0);
    do_learn("hit_prot", 48'h0000_0000_0ABC, 3'd2);
    check_lut(4'd3, 8'h81, 48'h0000_0000_0ABC, 1'b1);

    // Reset during CAM_WAIT restarts INIT; pending learn serviced afterwards
    expect_ev(EV_WR_ACK, '0, '0);
    expect_ev(EV_CAM_WE, 4'd5, 48'h0000_0000_0DEF);
    wr_addr    = 4'd5;
    wr_mac     = 48'h0000_0000_0DEF;
    wr_oq      = 8'h01;
    wr_protect = 1'b0;
    wr_req     = 1'b1;
    tick(1);
    wr_req = 1'b0;
    tick(3);
    expect_init();
    expect_ev(EV_CAM_WE, 4'd0, 48'h0000_0000_0600);
    expect_ev(EV_NEW, '0, '0);
    expect_ev(EV_ACK, '0, '0);
    reset      = 1'b1;
    learn_mac  = 48'h0000_0000_0600;
    learn_port = 3'd7;
    learn_req  = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(20);
    chk("mid_init_done", 64'(init_done), 0);
    chk("mid_init_ack", 64'(learn_ack), 0);
    wait_ack("after_reinit", 1500);
    learn_req = 1'b0;
    tick(2);
    chk("reinit_done", 64'(init_done), 1);
    check_lut(4'd0, 8'h80, 48'h0000_0000_0600, 1'b0);
    check_lut(4'd5, 8'h00, 48'h0, 1'b0);

    tick(30);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_cam_learner.md
# mac_cam_learner

Write-side companion to the learning switch's MAC CAM lookup path. Initialises the 16x48 MAC CAM and its shadow port table after reset, learns source MAC/port pairs from the packet path, and services host register writes. It owns the CAM write interface (`cam_we`, `cam_wr_addr`, `cam_din`, `cam_busy`). It also exports the per-entry output-port table that the lookup side indexes with the CAM match address.

## Interface
Parameters:
- `NUM_OUTPUT_QUEUES`, 8: width of one-hot output-queue vectors.
- `NUM_IQ_BITS`, 3: width of the source port number.
- `LUT_DEPTH_BITS`, 4: entry address width.
- `LUT_DEPTH`, 2**LUT_DEPTH_BITS: number of entries; the last entry holds the broadcast address.
- `DEFAULT_MISS_OUTPUT_PORTS`, 8'h55: output queues stored in the broadcast entry.

Ports:
- `clk`, in, 1: clock. All logic on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `learn_mac`, in, 48: source MAC to learn.
- `learn_port`, in, NUM_IQ_BITS: ingress port of `learn_mac`.
- `learn_req`, in, 1: learn request; held high until `learn_ack` is seen.
- `learn_ack`, out, 1: learn complete; stays high until `learn_req` falls.
- `wr_addr`, in, LUT_DEPTH_BITS: host write entry.
- `wr_req`, in, 1: host write request (level).
- `wr_oq`, in, NUM_OUTPUT_QUEUES: output queues to write.
- `wr_protect`, in, 1: protect bit to write.
- `wr_mac`, in, 48: MAC to write.
- `wr_ack`, out, 1: one-cycle pulse when the host write is issued.
- `cam_we`, out, 1: one-cycle CAM write strobe.
- `cam_wr_addr`, out, LUT_DEPTH_BITS: CAM write address.
- `cam_din`, out, 48: CAM write data.
- `cam_busy`, in, 1: CAM write in progress.
- `lut_rd_addr`, in, LUT_DEPTH_BITS: table read address (the lookup side drives the CAM match address).
- `lut_rd_oq`, out, NUM_OUTPUT_QUEUES: registered `oq` of the entry.
- `lut_rd_mac`, out, 48: registered `mac` of the entry.
- `lut_rd_protect`, out, 1: registered `protect` of the entry.
- `init_done`, out, 1: high once initialisation is complete.
- `learn_new`, out, 1: one-cycle pulse when a new entry is allocated.
- `learn_update`, out, 1: one-cycle pulse when an existing entry's port changes.
- `learn_drop`, out, 1: one-cycle pulse when a learn request is discarded.

## Operation
- Entry fields: `{valid, protect, oq[NUM_OUTPUT_QUEUES-1:0], mac[47:0]}`.
- States: INIT, IDLE, SEARCH, CAM_WR, CAM_WAIT.
- **INIT:**
  - Entered on reset. `init_ptr` starts at 0.
  - Entries 0..LUT_DEPTH-2 are written as `{0,0,0,48'h0}`.
  - Entry LUT_DEPTH-1 is written as `{1,1,DEFAULT_MISS_OUTPUT_PORTS,48'hFFFF_FFFF_FFFF}`.
  - Each entry gets one CAM write via CAM_WR then CAM_WAIT.
  - After the last entry completes, `init_done` rises and the FSM goes to IDLE.
  - No request is acknowledged while in INIT.
- **IDLE:**
  - `wr_req` has priority over learning. On `wr_req`: write the table entry at `wr_addr` with `{wr_mac!=0, wr_protect, wr_oq, wr_mac}`, pulse `wr_ack`, go to CAM_WR.
  - Otherwise, on `learn_req && !learn_ack`: latch the MAC and the decoded port, go to SEARCH.
- **SEARCH:** one cycle, parallel compare against all valid entries.
  - Drop (`learn_drop`, no write) if `mac==0` or `mac[40]` (group bit) is set.
  - Hit, entry protected or `oq` already equals the decoded port: no write, ack.
  - Hit, unprotected, `oq` differs: rewrite `oq` only, pulse `learn_update`, ack. The MAC is unchanged, so there is no CAM write.
  - Miss: take the lowest-index invalid entry. If none, take `victim_ptr` if that entry is unprotected. Write `{1,0,decoded,mac}`, pulse `learn_new`, go to CAM_WR.
  - Miss with no invalid entry and a protected victim: `learn_drop`, and `victim_ptr` advances.
  - `victim_ptr` ranges 0..LUT_DEPTH-2 and wraps to 0. It advances on every replacement or victim drop.
- **CAM_WR:**
  - Wait while `cam_busy` is high.
  - Then pulse `cam_we` with the latched address and data, go to CAM_WAIT.
- **CAM_WAIT:**
  - Spend at least one cycle here, then stay while `cam_busy` is high.
  - Exit to INIT (next entry, or IDLE after the last) or to IDLE.
  - On exit after a learn, set `learn_ack`.
- `learn_ack` clears on the cycle after `learn_req` is sampled low.
- An `oq` value is the one-hot decode of a port: bit `learn_port` set.

## Timing
- Reset values: `learn_ack`, `wr_ack`, `cam_we`, `learn_new`, `learn_update`, `learn_drop`, `init_done` are 0. `cam_wr_addr`, `cam_din`, `lut_rd_*` are 0. The FSM is in INIT.
- Learn without a CAM write: `learn_req` sampled in cycle N, SEARCH in N+1, `learn_ack` high in N+2.
- Learn with a CAM write: `cam_we` at N+2 if the CAM is idle, `learn_ack` the cycle after `cam_busy` is seen low.
- The table entry updates at SEARCH or the host-write cycle, so `lut_rd_*` reflect it 2 cycles later. While the CAM write is pending, lookups may miss and fall back to broadcast.
- Table read latency is 1 cycle.
- `cam_we` is never asserted while `cam_busy` is high or in two consecutive cycles.
- Reset mid-operation aborts any write, clears all acks and pulses, and restarts INIT. A pending `learn_req` is serviced after `init_done`.

## Structure
- Shared package holds:
  - state encodings
  - entry field offsets and widths
  - the broadcast MAC constant
  - the group-bit index (40)
- Sub-module `mac_learn_table` holds:
  - the entry register array
  - the write port
  - the registered read port
  - parallel match outputs: hit, hit index, lowest-free index, any-free

## Test plan
- Reset, `cam_busy` pulsing 16 cycles per write -> exactly 16 `cam_we`. Entry 15 = `{1,1,8'h55,FFFFFFFFFFFF}`, then `init_done`=1.
- Learn `00:11:22:33:44:55` port 2 -> `cam_we` to addr 0, `learn_new`. `lut_rd_addr`=0 gives `oq`=8'h04.
- Same MAC from port 4 -> no `cam_we`, `learn_update`, `oq`=8'h10, ack at N+2.
- Learn `01:00:5E:00:00:01` and `00:00:00:00:00:00` -> `learn_drop` twice, no `cam_we`.
- Fill 15 entries, then learn a 16th MAC -> written to `victim_ptr`=0. `victim_ptr` becomes 1. Entry 15 is never overwritten.
- `wr_req` and `learn_req` in the same cycle, `wr_addr`=3 -> `wr_ack` and a CAM write to 3 first, then the learn completes. `reset` during CAM_WAIT -> INIT restarts at entry 0.
